// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm controller: state encoding,
// time-field widths and the range check applied to alarm loads.
package alarm_pkg;

   localparam int HOUR_W     = 5;
   localparam int MIN_W      = 6;
   localparam int MAX_HOUR   = 23;
   localparam int MAX_MINUTE = 59;
   localparam int TIMER_W    = 6;

   typedef enum logic [1:0] {
      DISARMED = 2'd0,
      ARMED    = 2'd1,
      RINGING  = 2'd2,
      SNOOZE   = 2'd3
   } alarm_state_t;

   function automatic logic time_valid(input logic [HOUR_W-1:0] h,
                                       input logic [MIN_W-1:0]  m);
      return (h <= HOUR_W'(MAX_HOUR)) && (m <= MIN_W'(MAX_MINUTE));
   endfunction

endpackage

// File: rtl/alarm_min_timer.sv
// Minute down-counter shared by the ring timeout and the snooze period.
// Expires on the min_pulse that moves it from 1 to 0.
module alarm_min_timer
   import alarm_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_load,
   input  logic [TIMER_W-1:0] i_load_val,
   input  logic               i_min_pulse,
   output logic               o_expire
);

   logic [TIMER_W-1:0] r_count;

   // A load wins over a decrement so a reload on the expiry edge starts cleanly.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_min_pulse && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_expire = i_min_pulse && (r_count == TIMER_W'(1));

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm clock controller: stored alarm time, arm/ring/snooze FSM and buzzer.
// Define ALARM_BEEP_PATTERN_EN for a buzzer that toggles on each sec_pulse.
module alarm_ctrl
   import alarm_pkg::*;
#(
   parameter int SNOOZE_MIN       = 9,
   parameter int RING_TIMEOUT_MIN = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [HOUR_W-1:0] hour,
   input  logic [MIN_W-1:0]  minute,
   input  logic              sec_pulse,
   input  logic              min_pulse,
   input  logic              alarm_en,
   input  logic              set_alarm,
   input  logic [HOUR_W-1:0] set_hour,
   input  logic [MIN_W-1:0]  set_minute,
   input  logic              snooze,
   input  logic              stop,
   output logic [HOUR_W-1:0] alarm_hour,
   output logic [MIN_W-1:0]  alarm_minute,
   output logic              ringing,
   output logic              snoozing,
   output logic              buzzer
);

   alarm_state_t       r_state;
   alarm_state_t       w_next;
   logic [HOUR_W-1:0]  r_alarm_hour;
   logic [MIN_W-1:0]   r_alarm_minute;
   logic               r_match_q;
   logic               r_ringing;
   logic               r_snoozing;
   logic               r_buzzer;
   logic               w_match;
   logic               w_set_ok;
   logic               w_load;
   logic [TIMER_W-1:0] w_load_val;
   logic               w_expire;

   assign w_match  = (hour == r_alarm_hour) && (minute == r_alarm_minute);
   assign w_set_ok = set_alarm && time_valid(set_hour, set_minute);

   alarm_min_timer u_timer (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_load      (w_load),
      .i_load_val  (w_load_val),
      .i_min_pulse (min_pulse),
      .o_expire    (w_expire)
   );

   // NOTE: every output of this block gets a default first, so no path leaves
   // a signal unassigned and no latch is inferred.
   always_comb begin
      w_next     = r_state;
      w_load     = 1'b0;
      w_load_val = TIMER_W'(RING_TIMEOUT_MIN);
      if (!alarm_en) begin
         w_next = DISARMED;
      end else begin
         unique case (r_state)
            DISARMED: w_next = ARMED;
            ARMED: begin
               if (w_match && !r_match_q) begin
                  w_next = RINGING;
                  w_load = 1'b1;
               end
            end
            RINGING: begin
               if (w_set_ok || stop || w_expire) begin
                  w_next = ARMED;
               end else if (snooze) begin
                  w_next     = SNOOZE;
                  w_load     = 1'b1;
                  w_load_val = TIMER_W'(SNOOZE_MIN);
               end
            end
            SNOOZE: begin
               if (w_set_ok || stop) begin
                  w_next = ARMED;
               end else if (w_expire) begin
                  w_next = RINGING;
                  w_load = 1'b1;
               end
            end
            default: w_next = DISARMED;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state        <= DISARMED;
         r_alarm_hour   <= '0;
         r_alarm_minute <= '0;
         r_match_q      <= 1'b1;
         r_ringing      <= 1'b0;
         r_snoozing     <= 1'b0;
         r_buzzer       <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_match_q  <= w_match;
         r_ringing  <= (w_next == RINGING);
         r_snoozing <= (w_next == SNOOZE);
         if (w_set_ok) begin
            r_alarm_hour   <= set_hour;
            r_alarm_minute <= set_minute;
         end
`ifdef ALARM_BEEP_PATTERN_EN
         if (w_next != RINGING) begin
            r_buzzer <= 1'b0;
         end else if (r_state != RINGING) begin
            r_buzzer <= 1'b1;
         end else if (sec_pulse) begin
            r_buzzer <= ~r_buzzer;
         end
`else
         r_buzzer <= (w_next == RINGING);
`endif
      end
   end

`ifndef ALARM_BEEP_PATTERN_EN
   // Steady tone has no use for the seconds tick.
   logic w_unused_sec;
   assign w_unused_sec = sec_pulse;
`endif

   assign alarm_hour   = r_alarm_hour;
   assign alarm_minute = r_alarm_minute;
   assign ringing      = r_ringing;
   assign snoozing     = r_snoozing;
   assign buzzer       = r_buzzer;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scoreboard bench for alarm_ctrl: directed scenarios then random traffic,
// checked every cycle against a behavioural model of the alarm rules.
module tb_alarm_ctrl;

   localparam int SNZ = 9;
   localparam int TMO = 5;

   logic       clk = 1'b0;
   logic       rst_n, alarm_en, set_alarm, snooze, stop, sec_pulse, min_pulse;
   logic [4:0] hour, set_hour, alarm_hour;
   logic [5:0] minute, set_minute, alarm_minute;
   logic       ringing, snoozing, buzzer;

   alarm_ctrl #(.SNOOZE_MIN(SNZ), .RING_TIMEOUT_MIN(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .hour(hour), .minute(minute),
      .sec_pulse(sec_pulse), .min_pulse(min_pulse), .alarm_en(alarm_en),
      .set_alarm(set_alarm), .set_hour(set_hour), .set_minute(set_minute),
      .snooze(snooze), .stop(stop), .alarm_hour(alarm_hour),
      .alarm_minute(alarm_minute), .ringing(ringing), .snoozing(snoozing),
      .buzzer(buzzer)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       ring;
      logic       snz;
      logic       buzz;
      logic [4:0] ah;
      logic [5:0] am;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   // Reference model: wall-clock time plus the user-visible alarm situation.
   int cur_h = 0, cur_m = 0;
   bit tick_pend = 0;
   int m_ah = 0, m_am = 0, m_left = 0;
   bit m_on = 0, m_ring = 0, m_snz = 0, m_buzz = 0, m_prev = 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s cycle %0d: got %0d want %0d", name, cyc, act, want);
      end
   endtask

   task automatic model_step(input bit rst, en, sa, input int sh, sm, input bit sn, st, sp, mp);
      bit same_time, set_ok, timed_out, was_ring;
      same_time = (cur_h == m_ah) && (cur_m == m_am);
      set_ok    = sa && (sh <= 23) && (sm <= 59);
      timed_out = mp && (m_left == 1);
      was_ring  = m_ring;
      if (rst) begin
         m_ah = 0; m_am = 0; m_left = 0; m_prev = 1;
         m_on = 0; m_ring = 0; m_snz = 0; m_buzz = 0;
      end else begin
         if (set_ok) begin m_ah = sh; m_am = sm; end
         if (mp && m_left > 0) m_left--;
         if (!en) begin
            m_on = 0; m_ring = 0; m_snz = 0;
         end else if (!m_on) begin
            m_on = 1;
         end else if (m_ring) begin
            if (set_ok || st || timed_out) m_ring = 0;
            else if (sn) begin m_ring = 0; m_snz = 1; m_left = SNZ; end
         end else if (m_snz) begin
            if (set_ok || st) m_snz = 0;
            else if (timed_out) begin m_snz = 0; m_ring = 1; m_left = TMO; end
         end else if (same_time && !m_prev) begin
            m_ring = 1; m_left = TMO;
         end
         m_prev = same_time;
`ifdef ALARM_BEEP_PATTERN_EN
         if (!m_ring) m_buzz = 0;
         else if (!was_ring) m_buzz = 1;
         else if (sp) m_buzz = !m_buzz;
`else
         m_buzz = m_ring;
`endif
      end
      exp_q.push_back('{ring: m_ring, snz: m_snz, buzz: m_buzz,
                        ah: 5'(m_ah), am: 6'(m_am)});
   endtask

   task automatic advance_time();
      cur_m = (cur_m + 1) % 60;
      if (cur_m == 0) cur_h = (cur_h + 1) % 24;
   endtask

   task automatic set_time(input int h, m);
      cur_h = h; cur_m = m; tick_pend = 0;
   endtask

   task automatic step(input bit rst_b, en, sa, input int sh, sm, input bit sn, st, sp, mp);
      @(negedge clk);
      if (tick_pend) advance_time();
      rst_n = rst_b; alarm_en = en; set_alarm = sa;
      set_hour = 5'(sh); set_minute = 6'(sm);
      snooze = sn; stop = st; sec_pulse = sp; min_pulse = mp;
      hour = 5'(cur_h); minute = 6'(cur_m);
      model_step(!rst_b, en, sa, int'(set_hour), int'(set_minute), sn, st, sp, mp);
      tick_pend = mp;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1, 1, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic tick();
      step(1, 1, 0, 0, 0, 0, 0, 0, 1);
   endtask

   // Set the alarm one minute ahead and let the minute roll over onto it.
   task automatic arm_next();
      int nh, nm;
      nm = (cur_m + 1) % 60;
      nh = (nm == 0) ? (cur_h + 1) % 24 : cur_h;
      step(1, 1, 1, nh, nm, 0, 0, 0, 0);
      tick();
      idle(1);
   endtask

   // Monitor: compares every registered output one edge after the stimulus.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cyc++;
            check("ringing", ringing, e.ring);
            check("snoozing", snoozing, e.snz);
            check("buzzer", buzzer, e.buzz);
            check("alarm_hour", alarm_hour, e.ah);
            check("alarm_minute", alarm_minute, e.am);
         end
      end
   end

   initial begin
      int sh, sm, guard;
      bit rb, en, sa;
      set_time(6, 28);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0, 0, 0);
      idle(1);
      step(1, 1, 1, 6, 30, 0, 0, 0, 0);
      idle(2);
      tick();
      tick();
      idle(1);
      repeat (3) begin
         step(1, 1, 0, 0, 0, 0, 0, 1, 0);
         idle(1);
      end
      step(1, 1, 0, 0, 0, 0, 1, 0, 0);
      idle(5);

      step(1, 1, 1, 6, 32, 0, 0, 0, 0);
      tick();
      tick();
      idle(1);
      step(1, 1, 0, 0, 0, 1, 0, 0, 0);
      idle(1);
      repeat (SNZ) begin tick(); idle(2); end
      repeat (TMO) begin tick(); idle(1); end
      idle(2);

      arm_next();
      step(1, 1, 0, 0, 0, 1, 1, 0, 0);
      idle(2);

      step(1, 1, 1, 24, 10, 0, 0, 0, 0);
      step(1, 1, 1, 12, 60, 0, 0, 0, 0);
      step(1, 1, 1, 23, 59, 0, 0, 0, 0);
      idle(2);

      arm_next();
      step(0, 1, 0, 0, 0, 0, 0, 0, 0);
      idle(2);
      arm_next();
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(2);

      for (int i = 0; i < 3000; i++) begin
         rb = ($urandom_range(0, 399) != 0);
         en = ($urandom_range(0, 149) != 0);
         sa = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 1) == 0) begin
            sm = (cur_m + 1) % 60;
            sh = (sm == 0) ? (cur_h + 1) % 24 : cur_h;
         end else begin
            sh = $urandom_range(0, 26);
            sm = $urandom_range(0, 63);
         end
         step(rb, en, sa, sh, sm,
              $urandom_range(0, 24) == 0, $urandom_range(0, 49) == 0,
              $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0);
      end
      idle(2);

      guard = 0;
      while (exp_q.size() > 0 && guard < 10) begin
         @(posedge clk);
         guard++;
      end
      #2;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
